// File: rtl/regfile_debug_port.sv
// regfile_debug_port
//   8x16 register file for the pipelined processor, with a debug responder
//   that reads and writes registers over a four-phase req/ack handshake.
//   Register $0 is hard-wired to zero.
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   rd_addr_a/b, rd_data_a/b pipeline read ports, bypassed from writeback
//   wb_en, wb_addr, wb_data  pipeline writeback (wins over debug writes)
//   inr, out_value           observation read, never bypassed
//   dbg_req/we/addr/wdata    debug request, fields latched when req is taken
//   dbg_ack, dbg_rdata       registered acknowledge and read data
//   dbg_busy                 debug FSM not idle
//   dbg_stalls               saturating count of debug-write stall cycles
module regfile_debug_port #(
  parameter int unsigned RegAddrBits = 3,
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned TotalReg    = 2 ** RegAddrBits
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [RegAddrBits-1:0] rd_addr_a,
  output logic [DataWidth-1:0]   rd_data_a,
  input  logic [RegAddrBits-1:0] rd_addr_b,
  output logic [DataWidth-1:0]   rd_data_b,
  input  logic                   wb_en,
  input  logic [RegAddrBits-1:0] wb_addr,
  input  logic [DataWidth-1:0]   wb_data,
  input  logic [RegAddrBits-1:0] inr,
  output logic [DataWidth-1:0]   out_value,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [RegAddrBits-1:0] dbg_addr,
  input  logic [DataWidth-1:0]   dbg_wdata,
  output logic                   dbg_ack,
  output logic [DataWidth-1:0]   dbg_rdata,
  output logic                   dbg_busy,
  output logic [7:0]             dbg_stalls
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck, StRelease} state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   regs_q [TotalReg];
  logic [DataWidth-1:0]   regs_d [TotalReg];
  logic                   we_q, we_d;
  logic [RegAddrBits-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   ack_q, ack_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [7:0]             stalls_q, stalls_d;
  logic [DataWidth-1:0]   acc_rd;

  // $0 is never written, so regs_q[0] stays zero and needs no read guard.
  assign rd_data_a = (wb_en && (wb_addr == rd_addr_a) && (rd_addr_a != '0)) ? wb_data
                                                                             : regs_q[rd_addr_a];
  assign rd_data_b = (wb_en && (wb_addr == rd_addr_b) && (rd_addr_b != '0)) ? wb_data
                                                                             : regs_q[rd_addr_b];
  assign out_value = regs_q[inr];
  assign acc_rd    = (wb_en && (wb_addr == addr_q) && (addr_q != '0)) ? wb_data : regs_q[addr_q];

  assign dbg_ack    = ack_q;
  assign dbg_rdata  = rdata_q;
  assign dbg_busy   = (state_q != StIdle);
  assign dbg_stalls = stalls_q;

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    stalls_d = stalls_q;

    if (wb_en && (wb_addr != '0)) begin
      regs_d[wb_addr] = wb_data;
    end

    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = acc_rd;
          state_d = StAck;
        end else if (wb_en) begin
          // Writeback owns the write port this cycle; debug write waits.
          if (stalls_q != 8'hFF) begin
            stalls_d = stalls_q + 8'd1;
          end
        end else begin
          if (addr_q != '0) begin
            regs_d[addr_q] = wdata_q;
          end
          state_d = StAck;
        end
      end
      StAck: begin
        ack_d   = 1'b1;
        state_d = StRelease;
      end
      StRelease: begin
        if (!dbg_req) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      stalls_q <= '0;
      for (int i = 0; i < int'(TotalReg); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      stalls_q <= stalls_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
module tb_regfile_debug_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  rd_addr_a = '0, rd_addr_b = '0, wb_addr = '0, inr = '0, dbg_addr = '0;
  logic [15:0] rd_data_a, rd_data_b, out_value, dbg_rdata;
  logic [15:0] wb_data = '0, dbg_wdata = '0;
  logic        wb_en = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic        dbg_ack, dbg_busy;
  logic [7:0]  dbg_stalls;

  always #5 CLK = ~CLK;

  regfile_debug_port #(
    .RegAddrBits(3),
    .DataWidth  (16),
    .TotalReg   (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .inr       (inr),
    .out_value (out_value),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .dbg_busy  (dbg_busy),
    .dbg_stalls(dbg_stalls)
  );

  typedef enum int {SigRdA, SigRdB, SigOut, SigAck, SigBusy, SigStalls, SigRdata} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [15:0] exp;
  } probe_t;
  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic [7:0]  stalls;
    int          lat;
  } txn_t;

  probe_t probe_q[$];
  txn_t   ack_q[$];
  event   probe_ev;
  int     checks = 0;
  int     errors = 0;
  logic   mon_ack_prev = 1'b0;
  int     mon_cnt = 0;

  function automatic logic [15:0] sig_val(input sig_e s);
    case (s)
      SigRdA:    return rd_data_a;
      SigRdB:    return rd_data_b;
      SigOut:    return out_value;
      SigAck:    return {15'd0, dbg_ack};
      SigBusy:   return {15'd0, dbg_busy};
      SigStalls: return {8'd0, dbg_stalls};
      default:   return dbg_rdata;
    endcase
  endfunction

  // Level monitor: compares queued expectations against the current outputs.
  initial begin
    forever begin
      @(probe_ev);
      while (probe_q.size() > 0) begin
        probe_t      p;
        logic [15:0] got;
        p   = probe_q.pop_front();
        got = sig_val(p.sig);
        checks++;
        if (got !== p.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", p.name, got, p.exp);
        end
      end
    end
  end

  // Handshake monitor: on each rising ack, checks data, stalls and latency
  // (cycles from busy rising to ack rising).
  initial begin
    forever begin
      @(negedge CLK);
      if (dbg_ack && !mon_ack_prev) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack 1 expected no ack");
        end else begin
          txn_t t;
          t = ack_q.pop_front();
          checks += 3;
          if (dbg_rdata !== t.rdata) begin
            errors++;
            $display("FAIL %s_rdata: got %h expected %h", t.name, dbg_rdata, t.rdata);
          end
          if (dbg_stalls !== t.stalls) begin
            errors++;
            $display("FAIL %s_stalls: got %0d expected %0d", t.name, dbg_stalls, t.stalls);
          end
          if (mon_cnt != t.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", t.name, mon_cnt, t.lat);
          end
        end
      end
      if (!dbg_busy) mon_cnt = 0;
      else if (!dbg_ack) mon_cnt++;
      mon_ack_prev = dbg_ack;
    end
  end

  task automatic probe(input string n, input sig_e s, input logic [15:0] e);
    probe_q.push_back('{name: n, sig: s, exp: e});
    -> probe_ev;
    #1;
  endtask

  // Called just after a negedge; returns 1ns after the sampling edge, with
  // the request fields scrambled so only the latched copies can be correct.
  task automatic start_txn(input logic we, input logic [2:0] a, input logic [15:0] wd,
                           input string n, input logic [15:0] er, input logic [7:0] es,
                           input int lat);
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = wd;
    dbg_req   = 1'b1;
    ack_q.push_back('{name: n, rdata: er, stalls: es, lat: lat});
    @(posedge CLK);
    #1;
    dbg_we    = ~we;
    dbg_addr  = ~a;
    dbg_wdata = ~wd;
  endtask

  task automatic wait_ack(input string n);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (dbg_ack) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got ack 0 expected ack 1 within 20 cycles", n);
  endtask

  task automatic end_txn(input string n);
    dbg_req = 1'b0;
    @(negedge CLK);
    probe({n, "_ack_low"}, SigAck, 16'h0000);
    probe({n, "_busy_low"}, SigBusy, 16'h0000);
  endtask

  initial begin
    // 1: reset held with writeback active
    wb_en   = 1'b1;
    wb_addr = 3'd3;
    wb_data = 16'hFFFF;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      inr = 3'(i);
      probe($sformatf("reset_reg%0d", i), SigOut, 16'h0000);
    end
    probe("reset_ack", SigAck, 16'h0000);
    probe("reset_busy", SigBusy, 16'h0000);
    probe("reset_stalls", SigStalls, 16'h0000);
    probe("reset_rdata", SigRdata, 16'h0000);
    @(negedge CLK);
    wb_en = 1'b0;
    RST   = 1'b1;

    // 2: writeback, bypass, $0 ignore
    @(negedge CLK);
    wb_en     = 1'b1;
    wb_addr   = 3'd3;
    wb_data   = 16'hFFFE;
    rd_addr_a = 3'd3;
    inr       = 3'd3;
    probe("wb_bypass_a", SigRdA, 16'hFFFE);
    probe("wb_out_nobypass", SigOut, 16'h0000);
    @(negedge CLK);
    wb_addr   = 3'd0;
    wb_data   = 16'h1234;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    probe("wb_out_after", SigOut, 16'hFFFE);
    probe("zero_bypass_a", SigRdA, 16'h0000);
    probe("zero_bypass_b", SigRdB, 16'h0000);
    @(negedge CLK);
    wb_addr   = 3'd2;
    wb_data   = 16'h00A5;
    rd_addr_b = 3'd2;
    inr       = 3'd0;
    probe("zero_out", SigOut, 16'h0000);
    probe("wb_bypass_b", SigRdB, 16'h00A5);
    @(negedge CLK);
    wb_en     = 1'b0;
    rd_addr_a = 3'd3;
    probe("rd_a_stored", SigRdA, 16'hFFFE);
    probe("rd_b_stored", SigRdB, 16'h00A5);

    // 3: debug write $5, then read it back
    start_txn(1'b1, 3'd5, 16'h0014, "dbg_wr5", 16'h0000, 8'd0, 2);
    wait_ack("dbg_wr5");
    inr = 3'd5;
    probe("dbg_wr5_out", SigOut, 16'h0014);
    end_txn("dbg_wr5");
    start_txn(1'b0, 3'd5, 16'h0000, "dbg_rd5", 16'h0014, 8'd0, 2);
    wait_ack("dbg_rd5");
    end_txn("dbg_rd5");

    // 4: debug write $4 stalled by three writeback cycles
    @(negedge CLK);
    wb_en   = 1'b1;
    wb_addr = 3'd4;
    wb_data = 16'h1111;
    start_txn(1'b1, 3'd4, 16'h4444, "dbg_wr4_stall", 16'h0014, 8'd3, 5);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    wb_en = 1'b0;
    inr   = 3'd4;
    probe("stall_wb_visible", SigOut, 16'h1111);
    wait_ack("dbg_wr4_stall");
    probe("dbg_wr4_out", SigOut, 16'h4444);
    end_txn("dbg_wr4_stall");

    // 5: debug read $3 while writeback updates $3 during ACCESS
    @(negedge CLK);
    start_txn(1'b0, 3'd3, 16'h0000, "dbg_rd3_bypass", 16'h0015, 8'd3, 2);
    @(negedge CLK);
    wb_en   = 1'b1;
    wb_addr = 3'd3;
    wb_data = 16'h0015;
    @(negedge CLK);
    wb_en = 1'b0;
    wait_ack("dbg_rd3_bypass");
    inr = 3'd3;
    probe("rd3_out", SigOut, 16'h0015);
    end_txn("dbg_rd3_bypass");

    // 6: reset during ACCESS of a write aborts it
    @(negedge CLK);
    start_txn(1'b1, 3'd6, 16'hAAAA, "dbg_wr6_abort", 16'h0000, 8'd0, 2);
    void'(ack_q.pop_back());
    @(negedge CLK);
    RST     = 1'b0;
    dbg_req = 1'b0;
    inr     = 3'd6;
    probe("abort_ack", SigAck, 16'h0000);
    probe("abort_busy", SigBusy, 16'h0000);
    probe("abort_stalls", SigStalls, 16'h0000);
    probe("abort_reg6", SigOut, 16'h0000);
    @(negedge CLK);
    RST = 1'b1;
    probe("abort_reg6_after", SigOut, 16'h0000);
    @(negedge CLK);
    start_txn(1'b1, 3'd6, 16'h0666, "dbg_wr6_new", 16'h0000, 8'd0, 2);
    wait_ack("dbg_wr6_new");
    probe("dbg_wr6_out", SigOut, 16'h0666);
    end_txn("dbg_wr6_new");
    start_txn(1'b0, 3'd6, 16'h0000, "dbg_rd6", 16'h0666, 8'd0, 2);
    wait_ack("dbg_rd6");
    end_txn("dbg_rd6");
    start_txn(1'b0, 3'd0, 16'h0000, "dbg_rd0", 16'h0000, 8'd0, 2);
    wait_ack("dbg_rd0");
    end_txn("dbg_rd0");

    repeat (3) @(negedge CLK);
    if (ack_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_acks: got %0d pending expected 0", ack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
